// File: rtl/ex_muldiv.sv
// Iterative EX-stage multiply/divide unit with private HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module ex_muldiv #(
    parameter int                DATA_W  = 32,
    parameter int                CNT_W   = 6,
    parameter logic [DATA_W-1:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              stallreq
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    function automatic logic f_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [DATA_W-1:0] f_neg_w(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] f_neg_dw(input logic [2*DATA_W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Two's-complement magnitude; 0x8000_0000 maps to itself, read as unsigned.
    function automatic logic [DATA_W-1:0] f_mag(input logic signed [DATA_W-1:0] v, input logic is_signed);
        return f_neg_w(DATA_W'(v), is_signed && (v < 0));
    endfunction

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic                r_is_mul;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_div0;
    logic [DATA_W-1:0]   r_src_a;
    logic [2*DATA_W-1:0] r_acc;
    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_quo;
    logic [DATA_W-1:0]   r_dvs;

    logic                w_op_ok;
    logic                w_accept;
    logic                w_signed;
    logic                w_is_mul;
    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic [DATA_W:0]     w_shift;
    logic                w_fit;
    logic [DATA_W-1:0]   w_diff;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quo_s;
    logic [DATA_W-1:0]   w_rem_s;
    logic [DATA_W-1:0]   w_res_hi;
    logic [DATA_W-1:0]   w_res_lo;

    assign w_op_ok  = f_onehot4(op);
    assign w_accept = (r_state == S_IDLE) && start && w_op_ok && !flush;
    assign w_signed = op[3] | op[1];
    assign w_is_mul = op[3] | op[2];
    assign w_mag_a  = f_mag(src_a, w_signed);
    assign w_mag_b  = f_mag(src_b, w_signed);

    // Restoring division step: shift in the next dividend bit, subtract if it fits.
    assign w_shift  = {r_rem, r_quo[DATA_W-1]};
    assign w_fit    = (w_shift >= {1'b0, r_dvs});
    assign w_diff   = w_shift[DATA_W-1:0] - r_dvs;

    assign w_prod   = f_neg_dw(r_acc, r_neg_q);
    assign w_quo_s  = f_neg_w(r_quo, r_neg_q);
    assign w_rem_s  = f_neg_w(r_rem, r_neg_r);

    always_comb begin
        w_res_hi = w_rem_s;
        w_res_lo = w_quo_s;
        if (r_is_mul) begin
            w_res_hi = w_prod[2*DATA_W-1:DATA_W];
            w_res_lo = w_prod[DATA_W-1:0];
        end else if (r_div0) begin
            w_res_hi = r_src_a;
            w_res_lo = DIV0_LO;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= w_is_mul ? S_MUL : S_DIV;
                        r_cnt   <= '0;
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        r_state <= S_FIN;
`else
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_STEP) r_state <= S_FIN;
`endif
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (r_div0) begin
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_STEP) r_state <= S_FIN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    if (!flush) begin
                        r_hi <= w_res_hi;
                        r_lo <= w_res_lo;
                    end
                end
            endcase
        end
    end

    // Working registers are only meaningful after an accept, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_mul <= w_is_mul;
            r_src_a  <= src_a;
            r_div0   <= (src_b == '0);
            r_neg_q  <= w_signed & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
            r_neg_r  <= w_signed & src_a[DATA_W-1];
            r_acc    <= '0;
            r_mcand  <= {{DATA_W{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_rem    <= '0;
            r_quo    <= w_mag_a;
            r_dvs    <= w_mag_b;
        end else if (r_state == S_MUL) begin
`ifdef MULDIV_FAST_MUL_EN
            r_acc <= r_mcand * {{DATA_W{1'b0}}, r_mplier};
`else
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
`endif
        end else if (r_state == S_DIV && !r_div0) begin
            r_rem <= w_fit ? w_diff : w_shift[DATA_W-1:0];
            r_quo <= {r_quo[DATA_W-2:0], w_fit};
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_FIN) && !flush && rst;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign stallreq = ((r_state == S_IDLE) && start && w_op_ok) ||
                      (r_state == S_MUL) || (r_state == S_DIV);

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of decode.
- Consumes the two forwarded register operands (rs value, rt value) from the ID-to-EX bus and produces the HI/LO results for mult/multu/div/divu.
- Holds its own HI/LO registers.
- Raises a stall request toward the pipeline controller while an operation is in flight.

Parameters:
- DATA_W, 32: operand and result width. Only 32 is supported.
- CNT_W, 6: width of the iteration counter. Must satisfy 2^CNT_W > DATA_W.
- DIV0_LO, 32'hFFFF_FFFF: value written to LO on divide-by-zero.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- flush  in  1  abandon any in-flight operation.
- start  in  1  request a new operation this cycle.
- op  in  4  one-hot {mult, multu, div, divu}; bit3 = mult.
- src_a  in  32  rs operand, dividend / multiplicand.
- src_b  in  32  rt operand, divisor / multiplier.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse: HI/LO updated this cycle.
- hi  out  32  HI register.
- lo  out  32  LO register.
- stallreq  out  1  to the stall controller; holds the EX stage and everything upstream.

Behaviour:

Reset (rst=0 at a clock edge):
- state=IDLE; hi=0, lo=0, busy=0, done=0, counter=0.
- Applies mid-operation: partial results are discarded and HI/LO are cleared.

States: IDLE, MUL, DIV, FIN.
- IDLE: start=1 with a valid one-hot op captures src_a, src_b, op and goes to MUL or DIV.
  - Signed ops capture the operand magnitudes plus the result signs.
  - start with op=0 or non-one-hot is ignored and the block stays IDLE.
- MUL: one shift-add step per cycle; 32 steps, then FIN.
- DIV: one restoring-division step per cycle; 32 steps, then FIN.
  - If the captured divisor is 0, go straight to FIN after 1 cycle.
- FIN: write hi/lo, pulse done=1, return to IDLE.

Latency (accept at cycle 0):
- Normal mult/div: done=1 and new hi/lo visible after the edge at cycle 33.
- Divide-by-zero: done=1 at cycle 2.

busy:
- 1 in MUL, DIV and FIN.
- Asserted on the edge that accepts start; 0 in IDLE.

stallreq (combinational):
- stallreq = (state==IDLE & start & valid op) | (state==MUL) | (state==DIV).
- It is 0 in FIN, so the consuming instruction advances in the cycle where done=1.

start while busy: ignored. There is no queueing.

Arithmetic:
- mult: 64-bit signed product; hi=[63:32], lo=[31:0].
- multu: unsigned product, same mapping.
- div/divu: lo=quotient, hi=remainder.
- Signed divide:
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
  - Quotient truncates toward zero.
- Special case: div 0x8000_0000 by 0xFFFF_FFFF gives lo=0x8000_0000, hi=0. There is no trap.
- Divide-by-zero (signed or unsigned): hi=src_a as captured, lo=DIV0_LO.

flush:
- In MUL or DIV: go to IDLE on the next edge; hi/lo unchanged; done stays 0.
- In FIN: flush wins; no hi/lo write, no done.
- In IDLE: start is ignored that cycle.
- flush and rst together: rst wins.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: mult/multu complete with a single-cycle combinational 32x32 multiply. Path is IDLE to MUL (1 cycle) to FIN, so done=1 at cycle 2. stallreq is high only in the accept cycle and the MUL cycle.
- Undefined: iterative 32-step multiply as above, done at cycle 33.
- Division timing is identical either way.

Test Plan:
- multu a=0xFFFF_FFFF, b=0x0000_0002 → done at cycle 33, hi=0x0000_0001, lo=0xFFFF_FFFE; stallreq high for cycles 0..32, low at 33.
- mult a=0xFFFF_FFFD (-3), b=0x0000_0007 → hi=0xFFFF_FFFF, lo=0xFFFF_FFEB.
- div a=0xFFFF_FFF9 (-7), b=2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. divu with the same operands → lo=0x7FFF_FFFC, hi=1.
- divu a=0x1234, b=0 → done at cycle 2, hi=0x1234, lo=0xFFFF_FFFF.
- Start div with a=100, b=3, then assert flush at cycle 10 → busy=0 at cycle 11, done never pulses, hi/lo keep previous values. Next start is accepted normally.
- Assert rst=0 at cycle 15 of a mult → hi=lo=0, busy=0, stallreq=0. With MULDIV_FAST_MUL_EN defined, mult 5×6 gives done at cycle 2, lo=30, hi=0.
